// File: rtl/clock_mode_ctrl_multi.sv
// clock_mode_ctrl_multi: mode sequencer, multi-slot alarm with ring/snooze/timeout, and display mux
module clock_mode_ctrl_multi #(
    parameter int NUM_ALARMS     = 4,
    parameter int RING_SECONDS   = 60,
    parameter int SNOOZE_MINUTES = 5,
    localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  second_tick,
    input  logic                  mode_button,
    input  logic                  snooze_button,
    input  logic                  stop_alarm_button,
    input  logic [4:0]            normal_hours,
    input  logic [5:0]            normal_minutes,
    input  logic [4:0]            set_alarm_hours,
    input  logic [5:0]            set_alarm_minutes,
    input  logic                  on_off_alarm,
    input  logic                  set_alarm_ack_flag,
    input  logic [5:0]            stop_watch_minutes,
    input  logic [5:0]            stop_watch_seconds,
    input  logic                  stop_watch_ack_flag,
    input  logic [4:0]            set_time_hours,
    input  logic [5:0]            set_time_minutes,
    input  logic                  set_time_ack_flag,
    input  logic                  set_time_active,
    output logic                  set_time_en,
    output logic                  set_alarm_en,
    output logic                  stop_watch_en,
    output logic                  normal_en,
    output logic [AW-1:0]         alarm_sel,
    output logic [NUM_ALARMS-1:0] alarm_armed,
    output logic                  alarm_sound,
    output logic [AW-1:0]         alarm_id,
    output logic [5:0]            hours_fsm,
    output logic [5:0]            minutes_fsm
);
    localparam int CW = $clog2(RING_SECONDS + 1);

    typedef enum logic [1:0] {NORMAL, ALARM_SET, STOP_WATCH, SET_TIME} state_t;

    state_t                state, state_next;
    logic [AW-1:0]         sel_next;
    logic                  mode_prev, mode_pe, last_sel, write_slot;
    logic [4:0]            slot_h [NUM_ALARMS];
    logic [5:0]            slot_m [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] match, match_prev, match_rise;
    logic [AW-1:0]         first_id;
    logic                  snz_pending, snz_match, snz_prev, snz_rise, snz_cancel;
    logic [4:0]            snz_h, snz_h_new;
    logic [5:0]            snz_m, snz_m_new;
    logic [6:0]            msum;
    logic                  wrap;
    logic [CW-1:0]         ring_cnt;
    logic [5:0]            disp_h, disp_m;

    assign mode_pe    = mode_button & ~mode_prev;
    assign last_sel   = alarm_sel == AW'(NUM_ALARMS - 1);
    assign write_slot = (state == ALARM_SET) && set_alarm_ack_flag;

    assign set_alarm_en  = state == ALARM_SET;
    assign stop_watch_en = state == STOP_WATCH;
    assign set_time_en   = state == SET_TIME;
    assign normal_en     = (state == SET_TIME) && set_time_ack_flag && set_time_active;

    // Mode advance on a button rising edge; each mode except NORMAL needs its ack to leave
    always_comb begin
        state_next = state;
        sel_next   = alarm_sel;
        if (mode_pe) begin
            case (state)
                NORMAL: begin
                    state_next = ALARM_SET;
                    sel_next   = '0;
                end
                ALARM_SET: begin
                    if (set_alarm_ack_flag) begin
                        if (last_sel) state_next = STOP_WATCH;
                        else          sel_next   = alarm_sel + AW'(1);
                    end
                end
                STOP_WATCH: if (stop_watch_ack_flag) state_next = SET_TIME;
                default:    if (set_time_ack_flag)   state_next = NORMAL;
            endcase
        end
    end

    // Mode state, slot cursor and button history
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= NORMAL;
            alarm_sel <= '0;
            mode_prev <= 1'b0;
        end else begin
            state     <= state_next;
            alarm_sel <= sel_next;
            mode_prev <= mode_button;
        end
    end

    // Alarm slot storage; the entry is captured into the slot under edit while its ack is high
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                slot_h[i] <= '0;
                slot_m[i] <= '0;
            end
            alarm_armed <= '0;
        end else if (write_slot) begin
            slot_h[alarm_sel]      <= set_alarm_hours;
            slot_m[alarm_sel]      <= set_alarm_minutes;
            alarm_armed[alarm_sel] <= on_off_alarm;
        end
    end

    // Per-slot match against running time and lowest newly-matching slot
    always_comb begin
        match    = '0;
        first_id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            match[i] = alarm_armed[i] && (slot_h[i] == normal_hours) && (slot_m[i] == normal_minutes);
            if (match[i] && !match_prev[i]) first_id = AW'(i);
        end
    end

    assign match_rise = match & ~match_prev;
    assign snz_match  = snz_pending && (snz_h == normal_hours) && (snz_m == normal_minutes);
    assign snz_rise   = snz_match & ~snz_prev;
    assign snz_cancel = snz_pending && !alarm_armed[alarm_id];

    assign msum      = {1'b0, normal_minutes} + 7'(SNOOZE_MINUTES);
    assign wrap      = msum >= 7'd60;
    assign snz_m_new = wrap ? 6'(msum - 7'd60) : msum[5:0];
    assign snz_h_new = !wrap ? normal_hours : (normal_hours >= 5'd23 ? 5'd0 : normal_hours + 5'd1);

    // Ring control: start on a fresh match edge, end by stop > snooze > timeout
    always_ff @(posedge clk) begin
        if (!rst) begin
            alarm_sound <= 1'b0;
            alarm_id    <= '0;
            ring_cnt    <= '0;
            match_prev  <= '0;
            snz_prev    <= 1'b0;
        end else begin
            match_prev <= match;
            snz_prev   <= snz_match;
            if (!alarm_sound) begin
                if (|match_rise || snz_rise) begin
                    alarm_sound <= 1'b1;
                    ring_cnt    <= '0;
                    alarm_id    <= |match_rise ? first_id : alarm_id;
                end
            end else if (stop_alarm_button || snooze_button) begin
                alarm_sound <= 1'b0;
            end else if (second_tick) begin
                if (ring_cnt == CW'(RING_SECONDS - 1)) alarm_sound <= 1'b0;
                else                                   ring_cnt    <= ring_cnt + CW'(1);
            end
        end
    end

    // Snooze target: armed by a snooze press, consumed when it fires, dropped by stop or disarm
    always_ff @(posedge clk) begin
        if (!rst) begin
            snz_pending <= 1'b0;
            snz_h       <= '0;
            snz_m       <= '0;
        end else if (alarm_sound && stop_alarm_button) begin
            snz_pending <= 1'b0;
        end else if (alarm_sound && snooze_button) begin
            snz_pending <= 1'b1;
            snz_h       <= snz_h_new;
            snz_m       <= snz_m_new;
        end else if (snz_rise || snz_cancel) begin
            snz_pending <= 1'b0;
        end
    end

    // Display source selected by mode
    always_comb begin
        disp_h = state == NORMAL    ? {1'b0, normal_hours} :
                 state == ALARM_SET ? {1'b0, slot_h[alarm_sel]} :
                 state == STOP_WATCH ? stop_watch_minutes : {1'b0, set_time_hours};
        disp_m = state == NORMAL    ? normal_minutes :
                 state == ALARM_SET ? slot_m[alarm_sel] :
                 state == STOP_WATCH ? stop_watch_seconds : set_time_minutes;
    end

    // Registered display pair
    always_ff @(posedge clk) begin
        if (!rst) begin
            hours_fsm   <= '0;
            minutes_fsm <= '0;
        end else begin
            hours_fsm   <= disp_h;
            minutes_fsm <= disp_m;
        end
    end
endmodule

// File: tb/tb_clock_mode_ctrl_multi.sv
// tb_clock_mode_ctrl_multi: scoreboard bench for the mode sequencer and alarm logic
module tb_clock_mode_ctrl_multi;
    logic       clk = 0, rst;
    logic       second_tick, mode_button, snooze_button, stop_alarm_button;
    logic [4:0] normal_hours, set_alarm_hours, set_time_hours;
    logic [5:0] normal_minutes, set_alarm_minutes, set_time_minutes;
    logic [5:0] stop_watch_minutes, stop_watch_seconds;
    logic       on_off_alarm, set_alarm_ack_flag, stop_watch_ack_flag;
    logic       set_time_ack_flag, set_time_active;
    logic       set_time_en, set_alarm_en, stop_watch_en, normal_en, alarm_sound;
    logic [1:0] alarm_sel, alarm_id;
    logic [3:0] alarm_armed;
    logic [5:0] hours_fsm, minutes_fsm;

    localparam int SOUND = 0, ID = 1, SEL = 2, ARMED = 3, HRS = 4, MIN = 5, EN = 6, NEN = 7;

    typedef struct {
        string       name;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t        q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    int          n_tests = 0, n_fail = 0;

    clock_mode_ctrl_multi dut (
        .clk(clk), .rst(rst), .second_tick(second_tick), .mode_button(mode_button),
        .snooze_button(snooze_button), .stop_alarm_button(stop_alarm_button),
        .normal_hours(normal_hours), .normal_minutes(normal_minutes),
        .set_alarm_hours(set_alarm_hours), .set_alarm_minutes(set_alarm_minutes),
        .on_off_alarm(on_off_alarm), .set_alarm_ack_flag(set_alarm_ack_flag),
        .stop_watch_minutes(stop_watch_minutes), .stop_watch_seconds(stop_watch_seconds),
        .stop_watch_ack_flag(stop_watch_ack_flag), .set_time_hours(set_time_hours),
        .set_time_minutes(set_time_minutes), .set_time_ack_flag(set_time_ack_flag),
        .set_time_active(set_time_active), .set_time_en(set_time_en),
        .set_alarm_en(set_alarm_en), .stop_watch_en(stop_watch_en), .normal_en(normal_en),
        .alarm_sel(alarm_sel), .alarm_armed(alarm_armed), .alarm_sound(alarm_sound),
        .alarm_id(alarm_id), .hours_fsm(hours_fsm), .minutes_fsm(minutes_fsm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int s);
        case (s)
            SOUND:   return 32'(alarm_sound);
            ID:      return 32'(alarm_id);
            SEL:     return 32'(alarm_sel);
            ARMED:   return 32'(alarm_armed);
            HRS:     return 32'(hours_fsm);
            MIN:     return 32'(minutes_fsm);
            EN:      return 32'({set_time_en, stop_watch_en, set_alarm_en});
            default: return 32'(normal_en);
        endcase
    endfunction

    // Expected outputs after the next clock edge
    task automatic chk(input string n, input int s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sig  = s;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_alarm(input logic [4:0] h, input logic [5:0] m, input logic on);
        set_alarm_hours   = h;
        set_alarm_minutes = m;
        on_off_alarm      = on;
    endtask

    task automatic press(input logic aack, input logic [4:0] h, input logic [5:0] m,
                         input logic on, input logic swack, input logic stack);
        mode_button = 1; set_alarm_ack_flag = aack; set_alarm(h, m, on);
        stop_watch_ack_flag = swack; set_time_ack_flag = stack;
        cyc();
        mode_button = 0; set_alarm_ack_flag = 0; stop_watch_ack_flag = 0; set_time_ack_flag = 0;
        cyc();
    endtask

    task automatic set_now(input logic [4:0] h, input logic [5:0] m);
        normal_hours   = h;
        normal_minutes = m;
    endtask

    // Monitor: compare all queued expectations just after each active edge
    always @(posedge clk) begin
        #1;
        while (q.size() > 0) begin
            mon_e   = q.pop_front();
            mon_act = actual(mon_e.sig);
            n_tests++;
            if (mon_act !== mon_e.exp) begin
                n_fail++;
                $display("FAIL %s: actual=%0d expected=%0d", mon_e.name, mon_act, mon_e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; second_tick = 0; mode_button = 0; snooze_button = 0; stop_alarm_button = 0;
        set_now(10, 0); set_alarm(0, 0, 0); set_alarm_ack_flag = 0;
        stop_watch_minutes = 0; stop_watch_seconds = 0; stop_watch_ack_flag = 0;
        set_time_hours = 0; set_time_minutes = 0; set_time_ack_flag = 0; set_time_active = 0;
        chk("rst_sound", SOUND, 0); chk("rst_armed", ARMED, 0); chk("rst_sel", SEL, 0);
        chk("rst_en", EN, 0); chk("rst_hrs", HRS, 0);
        cyc();
        rst = 1; chk("disp_h_10", HRS, 10); chk("disp_m_00", MIN, 0); chk("idle_sound", SOUND, 0);
        cyc();
        mode_button = 1; chk("to_alarm_set", EN, 1); chk("sel0", SEL, 0);
        cyc();
        set_alarm(6, 0, 1); set_alarm_ack_flag = 1; chk("held_sel", SEL, 0); chk("held_en", EN, 1);
        cyc();
        mode_button = 0; set_alarm_ack_flag = 0;
        chk("slot0_disp_h", HRS, 6); chk("slot0_disp_m", MIN, 0); chk("armed0", ARMED, 4'b0001);
        cyc();
        mode_button = 1; set_alarm_ack_flag = 1; chk("sel1", SEL, 1);
        cyc();
        mode_button = 0; set_alarm_ack_flag = 0;
        cyc();
        mode_button = 1; set_alarm_ack_flag = 1; set_alarm(0, 0, 0); chk("sel2", SEL, 2);
        cyc();
        mode_button = 0; set_alarm_ack_flag = 0;
        cyc();
        mode_button = 1; set_alarm_ack_flag = 1; set_alarm(7, 30, 1);
        chk("sel3", SEL, 3); chk("armed02", ARMED, 4'b0101);
        cyc();
        mode_button = 0; set_alarm_ack_flag = 0;
        cyc();
        mode_button = 1; chk("noack_sel", SEL, 3); chk("noack_en", EN, 1);
        cyc();
        mode_button = 0;
        cyc();
        mode_button = 1; set_alarm_ack_flag = 1; set_alarm(6, 0, 1);
        chk("to_stop_watch", EN, 2); chk("armed023", ARMED, 4'b1101);
        cyc();
        mode_button = 0; set_alarm_ack_flag = 0; stop_watch_minutes = 12; stop_watch_seconds = 34;
        chk("sw_disp_h", HRS, 12); chk("sw_disp_m", MIN, 34);
        cyc();
        mode_button = 1; chk("sw_noack", EN, 2);
        cyc();
        mode_button = 0;
        cyc();
        mode_button = 1; stop_watch_ack_flag = 1; chk("to_set_time", EN, 4);
        cyc();
        mode_button = 0; stop_watch_ack_flag = 0; set_time_hours = 8; set_time_minutes = 15;
        set_time_ack_flag = 1; set_time_active = 1;
        chk("normal_en", NEN, 1); chk("st_disp_h", HRS, 8); chk("st_disp_m", MIN, 15);
        cyc();
        mode_button = 1; set_time_active = 0; chk("to_normal", EN, 0); chk("nen_off", NEN, 0);
        cyc();
        mode_button = 0; set_time_ack_flag = 0; set_now(7, 29);
        chk("norm_disp_h", HRS, 7); chk("norm_disp_m", MIN, 29); chk("pre_ring", SOUND, 0);
        cyc();
        set_now(7, 30); chk("ring_slot2", SOUND, 1); chk("ring_id2", ID, 2);
        cyc();
        stop_alarm_button = 1; chk("stop", SOUND, 0);
        cyc();
        stop_alarm_button = 0; chk("no_refire", SOUND, 0);
        cyc();
        chk("no_refire2", SOUND, 0);
        cyc();
        set_now(6, 0); chk("ring_dual", SOUND, 1); chk("ring_dual_id", ID, 0);
        cyc();
        stop_alarm_button = 1; chk("stop_dual", SOUND, 0);
        cyc();
        stop_alarm_button = 0; chk("single_ring", SOUND, 0);
        cyc();
        chk("single_ring2", SOUND, 0);
        cyc();
        set_now(12, 0);
        cyc();
        press(0, 0, 0, 0, 0, 0);
        press(1, 6, 0, 1, 0, 0);
        press(1, 23, 58, 1, 0, 0);
        press(1, 7, 30, 1, 0, 0);
        press(1, 6, 0, 1, 0, 0);
        press(0, 0, 0, 0, 1, 0);
        press(0, 0, 0, 0, 0, 1);
        chk("walk2_en", EN, 0); chk("armed_all", ARMED, 4'b1111);
        cyc();
        set_now(23, 57);
        cyc();
        set_now(23, 58); chk("ring_2358", SOUND, 1); chk("ring_2358_id", ID, 1);
        cyc();
        snooze_button = 1; chk("snooze", SOUND, 0);
        cyc();
        snooze_button = 0; set_now(23, 59); chk("snoozed_2359", SOUND, 0);
        cyc();
        set_now(0, 2); chk("snoozed_0002", SOUND, 0);
        cyc();
        set_now(0, 3); chk("snooze_ring", SOUND, 1); chk("snooze_id", ID, 1);
        cyc();
        stop_alarm_button = 1; chk("snooze_stop", SOUND, 0);
        cyc();
        stop_alarm_button = 0;
        cyc();
        set_now(7, 29);
        cyc();
        set_now(7, 30); chk("ring_to", SOUND, 1); chk("ring_to_id", ID, 2);
        cyc();
        for (int i = 0; i < 59; i++) begin
            second_tick = 1;
            cyc();
            second_tick = 0;
            cyc();
        end
        chk("ring_59", SOUND, 1);
        cyc();
        second_tick = 1; chk("timeout", SOUND, 0);
        cyc();
        second_tick = 0;
        cyc();
        set_now(7, 29);
        cyc();
        set_now(7, 30); chk("ring_rst", SOUND, 1);
        cyc();
        rst = 0; chk("rst_ring_sound", SOUND, 0); chk("rst_ring_armed", ARMED, 0);
        chk("rst_ring_id", ID, 0); chk("rst_ring_en", EN, 0);
        cyc();
        rst = 1;
        cyc();
        cyc();
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: actual=%0d expected=0 pending checks", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
